// File: rtl/uart_rx_fifo_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package   : uart_rx_fifo_pkg                                               |
// | Purpose   : Shared UART sizing constants (data width, RX FIFO depth and    |
// |             almost-full level) plus a saturating counter helper used by    |
// |             the receive buffer.                                            |
// | Ports     : none                                                           |
// | Revision  : 1.0 - initial release                                          |
// +----------------------------------------------------------------------------+
package uart_rx_fifo_pkg;

  localparam int UART_DATA_W       = 8;
  localparam int UART_RXFIFO_DEPTH = 16;
  localparam int UART_RXFIFO_AF    = 12;

  // Increment that sticks at the all-ones value instead of wrapping.
  function automatic logic [7:0] sat_inc8(input logic [7:0] value);
    return (value == 8'hFF) ? value : value + 8'd1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_fifo_mem.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module    : uart_fifo_mem                                                  |
// | Purpose   : DEPTH x DATA_W storage with one synchronous write port and one |
// |             registered read port. A read of the address being written in   |
// |             the same cycle returns the new write data.                     |
// | Ports     : bclk, reset (async, active-high, clears rd_data only)          |
// |             wr_en/wr_addr/wr_data  - write port                            |
// |             rd_en/rd_addr/rd_data  - registered read port                  |
// | Revision  : 1.0 - initial release                                          |
// +----------------------------------------------------------------------------+
module uart_fifo_mem
  import uart_rx_fifo_pkg::*;
#(
  parameter int DATA_W = UART_DATA_W,
  parameter int DEPTH  = UART_RXFIFO_DEPTH,
  parameter int ADDR_W = 4
) (
  input  logic              bclk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_rd_data;

  // Storage is deliberately not reset.
  always_ff @(posedge bclk) begin
    if (wr_en) begin
      r_mem[wr_addr] <= wr_data;
    end
  end

  // Bypass lets a write into an empty FIFO reach the head register on the
  // same edge the array is written.
  always_ff @(posedge bclk or posedge reset) begin
    if (reset) begin
      r_rd_data <= '0;
    end else if (rd_en) begin
      r_rd_data <= (wr_en && (wr_addr == rd_addr)) ? wr_data : r_mem[rd_addr];
    end
  end

  assign rd_data = r_rd_data;

endmodule
`default_nettype wire

// File: rtl/uart_rx_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module    : uart_rx_fifo                                                   |
// | Purpose   : Receive buffer behind the UART receiver. Captures each strobed |
// |             byte into a circular FIFO, presents the oldest byte through a  |
// |             first-word-fall-through valid/ready port, and reports fill     |
// |             level, almost-full and sticky/counted overruns.                |
// | Ports     : bclk, reset (async, active-high)                               |
// |             wr_data/wr_en          - bytes from the receiver              |
// |             rd_data/rd_valid/rd_ready - host read port                     |
// |             count/full/almost_full  - fill status                          |
// |             overrun/overrun_cnt/overrun_clr - dropped-byte reporting       |
// | Revision  : 1.0 - initial release                                          |
// +----------------------------------------------------------------------------+
module uart_rx_fifo
  import uart_rx_fifo_pkg::*;
#(
  parameter int DATA_W   = UART_DATA_W,
  parameter int DEPTH    = UART_RXFIFO_DEPTH,
  parameter int ADDR_W   = 4,
  parameter int AF_LEVEL = UART_RXFIFO_AF
) (
  input  logic              bclk,
  input  logic              reset,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              wr_en,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              almost_full,
  output logic              overrun,
  output logic [7:0]        overrun_cnt,
  input  logic              overrun_clr
);

  localparam logic [ADDR_W:0]   c_depth    = DEPTH[ADDR_W:0];
  localparam logic [ADDR_W:0]   c_af_level = AF_LEVEL[ADDR_W:0];
  localparam logic [ADDR_W-1:0] c_ptr_one  = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [ADDR_W:0]   c_cnt_one  = {{ADDR_W{1'b0}}, 1'b1};

  logic [ADDR_W-1:0] r_wr_ptr;
  logic [ADDR_W-1:0] r_rd_ptr;
  logic [ADDR_W:0]   r_count;
  logic              r_rd_valid;
  logic              r_full;
  logic              r_almost_full;
  logic              r_overrun;
  logic [7:0]        r_overrun_cnt;

  logic              w_pop;
  logic              w_write;
  logic              w_overrun;
  logic [ADDR_W-1:0] w_rd_ptr_inc;
  logic [ADDR_W:0]   w_count_nxt;
  logic              w_head_load;
  logic [ADDR_W-1:0] w_head_addr;

  assign w_pop        = r_rd_valid & rd_ready;
  // A pop frees a slot in the same cycle, so a full FIFO still accepts.
  assign w_write      = wr_en & (~r_full | w_pop);
  assign w_overrun    = wr_en & r_full & ~w_pop;
  assign w_rd_ptr_inc = r_rd_ptr + c_ptr_one;

  always_comb begin
    w_count_nxt = r_count;
    case ({w_write, w_pop})
      2'b10:   w_count_nxt = r_count + c_cnt_one;
      2'b01:   w_count_nxt = r_count - c_cnt_one;
      default: w_count_nxt = r_count;
    endcase
  end

  // The head register only moves on a pop or on a write into an empty FIFO,
  // which keeps rd_data stable while the host stalls.
  assign w_head_load = w_pop | (w_write & ~r_rd_valid);
  assign w_head_addr = w_pop ? w_rd_ptr_inc : r_rd_ptr;

  always_ff @(posedge bclk or posedge reset) begin
    if (reset) begin
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
      r_count       <= '0;
      r_rd_valid    <= 1'b0;
      r_full        <= 1'b0;
      r_almost_full <= 1'b0;
      r_overrun     <= 1'b0;
      r_overrun_cnt <= '0;
    end else begin
      if (w_write) begin
        r_wr_ptr <= r_wr_ptr + c_ptr_one;
      end
      if (w_pop) begin
        r_rd_ptr <= w_rd_ptr_inc;
      end
      r_count       <= w_count_nxt;
      r_rd_valid    <= (w_count_nxt != '0);
      r_full        <= (w_count_nxt == c_depth);
      r_almost_full <= (w_count_nxt >= c_af_level);
      // A fresh overrun takes priority over a clear in the same cycle.
      if (w_overrun) begin
        r_overrun     <= 1'b1;
        r_overrun_cnt <= overrun_clr ? 8'd1 : sat_inc8(r_overrun_cnt);
      end else if (overrun_clr) begin
        r_overrun     <= 1'b0;
        r_overrun_cnt <= '0;
      end
    end
  end

  uart_fifo_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_mem (
    .bclk    (bclk),
    .reset   (reset),
    .wr_en   (w_write),
    .wr_addr (r_wr_ptr),
    .wr_data (wr_data),
    .rd_en   (w_head_load),
    .rd_addr (w_head_addr),
    .rd_data (rd_data)
  );

  assign rd_valid    = r_rd_valid;
  assign count       = r_count;
  assign full        = r_full;
  assign almost_full = r_almost_full;
  assign overrun     = r_overrun;
  assign overrun_cnt = r_overrun_cnt;

endmodule
`default_nettype wire
